// File: rtl/mac_simd.sv
// Signed SIMD multiply-accumulate with guard-bit accumulator, per-lane saturation
// and a stall-freezable output queue of PIPE_DEPTH snapshots.
module mac_simd #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 2,
  parameter int GUARD      = 8,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            instruction,
  input  logic [DATA_W-1:0]     multiplier,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic                  stall,
  output logic [2*DATA_W-1:0]   result,
  output logic [GUARD-1:0]      protect,
  output logic [LANES-1:0]      sat,
  output logic                  out_valid
);

  localparam int L  = DATA_W / LANES;
  localparam int G  = GUARD / LANES;
  localparam int N  = 2 * DATA_W;
  localparam int FW = N + GUARD;
  localparam int LW = 2 * L + G;

  typedef struct packed {
    logic [GUARD-1:0] g;
    logic [N-1:0]     lo;
    logic [LANES-1:0] sat;
    logic             vld;
  } entry_t;

  logic [N-1:0]     acc_lo_q, acc_lo_d;
  logic [GUARD-1:0] acc_g_q, acc_g_d;
  entry_t           q_q [PIPE_DEPTH];
  entry_t           q_d [PIPE_DEPTH];
  entry_t           out_q, out_d;

  // Full-mode datapath: low N bits of the product of sign-extended operands
  // equal the signed product.
  logic [N-1:0]  full_a_ext, full_b_ext, full_prod;
  logic [FW-1:0] full_acc, full_prod_ext, full_sum, full_clamp;
  logic [GUARD:0] full_top;
  logic          full_ovf;

  assign full_a_ext    = {{DATA_W{multiplier[DATA_W-1]}}, multiplier};
  assign full_b_ext    = {{DATA_W{multiplicand[DATA_W-1]}}, multiplicand};
  assign full_prod     = full_a_ext * full_b_ext;
  assign full_acc      = {acc_g_q, acc_lo_q};
  assign full_prod_ext = {{GUARD{full_prod[N-1]}}, full_prod};
  assign full_sum      = full_acc + full_prod_ext;
  assign full_top      = full_acc[FW-1:N-1];
  assign full_ovf      = !((&full_top) || !(|full_top));
  assign full_clamp    = !full_ovf ? full_acc :
                         (full_acc[FW-1] ? {{(GUARD+1){1'b1}}, {(N-1){1'b0}}}
                                         : {{(GUARD+1){1'b0}}, {(N-1){1'b1}}});

  logic [N-1:0]     lane_mul_lo, lane_mac_lo, lane_sat_lo;
  logic [GUARD-1:0] lane_mul_g, lane_mac_g, lane_sat_g;
  logic [LANES-1:0] lane_ovf;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [L-1:0]   a, b;
      logic [2*L-1:0] a_ext, b_ext, prod;
      logic [LW-1:0]  acc, prod_ext, sum, clamp;
      logic [G:0]     top;
      logic           ovf;

      assign a        = multiplier[gi*L +: L];
      assign b        = multiplicand[gi*L +: L];
      assign a_ext    = {{L{a[L-1]}}, a};
      assign b_ext    = {{L{b[L-1]}}, b};
      assign prod     = a_ext * b_ext;
      assign acc      = {acc_g_q[gi*G +: G], acc_lo_q[gi*2*L +: 2*L]};
      assign prod_ext = {{G{prod[2*L-1]}}, prod};
      assign sum      = acc + prod_ext;
      assign top      = acc[LW-1:2*L-1];
      assign ovf      = !((&top) || !(|top));
      assign clamp    = !ovf ? acc :
                        (acc[LW-1] ? {{(G+1){1'b1}}, {(2*L-1){1'b0}}}
                                   : {{(G+1){1'b0}}, {(2*L-1){1'b1}}});

      assign lane_mul_lo[gi*2*L +: 2*L] = prod_ext[2*L-1:0];
      assign lane_mul_g[gi*G +: G]      = prod_ext[LW-1:2*L];
      assign lane_mac_lo[gi*2*L +: 2*L] = sum[2*L-1:0];
      assign lane_mac_g[gi*G +: G]      = sum[LW-1:2*L];
      assign lane_sat_lo[gi*2*L +: 2*L] = clamp[2*L-1:0];
      assign lane_sat_g[gi*G +: G]      = clamp[LW-1:2*L];
      assign lane_ovf[gi]               = ovf;
    end
  endgenerate

  logic [LANES-1:0] new_sat;
  logic             new_vld;

  always_comb begin
    acc_lo_d = acc_lo_q;
    acc_g_d  = acc_g_q;
    new_sat  = '0;
    new_vld  = 1'b0;
    case (instruction)
      3'b000: ;
      3'b100: begin
        acc_lo_d = '0;
        acc_g_d  = '0;
      end
      3'b001: begin
        {acc_g_d, acc_lo_d} = full_prod_ext;
        new_vld = 1'b1;
      end
      3'b010: begin
        {acc_g_d, acc_lo_d} = full_sum;
        new_vld = 1'b1;
      end
      3'b011: begin
        {acc_g_d, acc_lo_d} = full_clamp;
        new_sat = {LANES{full_ovf}};
        new_vld = 1'b1;
      end
      3'b101: begin
        {acc_g_d, acc_lo_d} = {lane_mul_g, lane_mul_lo};
        new_vld = 1'b1;
      end
      3'b110: begin
        {acc_g_d, acc_lo_d} = {lane_mac_g, lane_mac_lo};
        new_vld = 1'b1;
      end
      3'b111: begin
        {acc_g_d, acc_lo_d} = {lane_sat_g, lane_sat_lo};
        new_sat = lane_ovf;
        new_vld = 1'b1;
      end
    endcase
    // A stalled edge drops the opcode entirely rather than deferring it.
    if (stall) begin
      acc_lo_d = acc_lo_q;
      acc_g_d  = acc_g_q;
    end
  end

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < PIPE_DEPTH; k++) q_d[k] = q_q[k];
    if (!stall) begin
      out_d = q_q[0];
      for (int k = 0; k < PIPE_DEPTH - 1; k++) q_d[k] = q_q[k+1];
      q_d[PIPE_DEPTH-1] = '{g: acc_g_d, lo: acc_lo_d, sat: new_sat, vld: new_vld};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_lo_q <= '0;
      acc_g_q  <= '0;
      out_q    <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) q_q[k] <= '0;
    end else begin
      acc_lo_q <= acc_lo_d;
      acc_g_q  <= acc_g_d;
      out_q    <= out_d;
      for (int k = 0; k < PIPE_DEPTH; k++) q_q[k] <= q_d[k];
    end
  end

  assign result    = out_q.lo;
  assign protect   = out_q.g;
  assign sat       = out_q.sat;
  assign out_valid = out_q.vld;

endmodule

// File: tb/tb_mac_simd.sv
// Bench for mac_simd: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an integer-arithmetic model.
module tb_mac_simd;

  localparam int DATA_W = 16;
  localparam int LANES = 2;
  localparam int GUARD = 8;
  localparam int PIPE_DEPTH = 2;
  localparam longint MAXF = 64'sd2147483647;
  localparam longint MINF = -64'sd2147483648;
  localparam longint MAXL = 64'sd32767;
  localparam longint MINL = -64'sd32768;

  logic        clk;
  logic        reset;
  logic [2:0]  instruction;
  logic [15:0] multiplier, multiplicand;
  logic        stall;
  logic [31:0] result;
  logic [7:0]  protect;
  logic [1:0]  sat;
  logic        out_valid;

  mac_simd #(.DATA_W(DATA_W), .LANES(LANES), .GUARD(GUARD), .PIPE_DEPTH(PIPE_DEPTH)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .multiplier(multiplier), .multiplicand(multiplicand), .stall(stall),
    .result(result), .protect(protect), .sat(sat), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [7:0]  g;
    logic [1:0]  sat;
    logic        vld;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        exp_out;
  logic [39:0] m_acc;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  function automatic ent_t zero_ent();
    ent_t e;
    e.lo = '0; e.g = '0; e.sat = '0; e.vld = 1'b0;
    return e;
  endfunction

  // Accumulator treated as signed integers: full 40-bit value or two 20-bit lanes.
  function automatic ent_t model_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    ent_t e;
    longint v, p;
    logic signed [39:0] f;
    logic signed [19:0] t;
    logic signed [15:0] sa, sb;
    logic signed [7:0]  a8, b8;
    logic [63:0] vb;
    e = zero_ent();
    e.vld = (op != 3'd0) && (op != 3'd4);
    if (op == 3'd4) begin
      m_acc = '0;
    end else if (op >= 3'd1 && op <= 3'd3) begin
      f = m_acc; v = f; sa = a; sb = b;
      p = longint'(sa) * longint'(sb);
      if (op == 3'd1) v = p;
      else if (op == 3'd2) v = v + p;
      else if (v > MAXF) begin v = MAXF; e.sat = 2'b11; end
      else if (v < MINF) begin v = MINF; e.sat = 2'b11; end
      vb = v;
      m_acc = vb[39:0];
    end else if (op >= 3'd5) begin
      for (int i = 0; i < 2; i++) begin
        t = {m_acc[32+i*4 +: 4], m_acc[i*16 +: 16]};
        v = t; a8 = a[i*8 +: 8]; b8 = b[i*8 +: 8];
        p = longint'(a8) * longint'(b8);
        if (op == 3'd5) v = p;
        else if (op == 3'd6) v = v + p;
        else if (v > MAXL) begin v = MAXL; e.sat[i] = 1'b1; end
        else if (v < MINL) begin v = MINL; e.sat[i] = 1'b1; end
        vb = v;
        m_acc[32+i*4 +: 4] = vb[19:16];
        m_acc[i*16 +: 16]  = vb[15:0];
      end
    end
    e.lo = m_acc[31:0];
    e.g  = m_acc[39:32];
    return e;
  endfunction

  task automatic model_reset();
    m_acc = '0;
    exp_q.delete();
    for (int k = 0; k < PIPE_DEPTH; k++) exp_q.push_back(zero_ent());
    exp_out = zero_ent();
  endtask

  task automatic compare(input string tag);
    checks++;
    if (result !== exp_out.lo || protect !== exp_out.g || sat !== exp_out.sat || out_valid !== exp_out.vld) begin
      errors++;
      $display("FAIL %s cyc=%0d got res=%h prot=%h sat=%b vld=%b want res=%h prot=%h sat=%b vld=%b",
               tag, cyc, result, protect, sat, out_valid, exp_out.lo, exp_out.g, exp_out.sat, exp_out.vld);
    end else begin
      $display("ok   %s cyc=%0d op=%0d stall=%b res=%h prot=%h sat=%b vld=%b",
               tag, cyc, instruction, stall, result, protect, sat, out_valid);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [31:0] r, input logic [7:0] p, input logic [1:0] s, input logic v);
    checks++;
    if (result !== r || protect !== p || sat !== s || out_valid !== v) begin
      errors++;
      $display("FAIL %s dut res=%h prot=%h sat=%b vld=%b required res=%h prot=%h sat=%b vld=%b",
               name, result, protect, sat, out_valid, r, p, s, v);
    end
    checks++;
    if (exp_out.lo !== r || exp_out.g !== p || exp_out.sat !== s || exp_out.vld !== v) begin
      errors++;
      $display("FAIL %s model res=%h prot=%h sat=%b vld=%b required res=%h prot=%h sat=%b vld=%b",
               name, exp_out.lo, exp_out.g, exp_out.sat, exp_out.vld, r, p, s, v);
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic st);
    ent_t e;
    instruction = op; multiplier = a; multiplicand = b; stall = st;
    @(posedge clk);
    cyc++;
    if (!st) begin
      e = model_op(op, a, b);
      exp_out = exp_q.pop_front();
      exp_q.push_back(e);
    end
    #1;
    compare("cyc");
  endtask

  // Asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    lit("rst_async", 32'h0, 8'h0, 2'b00, 1'b0);
    @(posedge clk);
    cyc++;
    #1;
    compare("rst_hold");
    reset = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 5))
      0: return 8'h7F;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; instruction = 3'd0; multiplier = '0; multiplicand = '0; stall = 1'b0;
    model_reset();

    // Reset and latency
    do_reset();
    step(3'b001, 16'hFFFF, 16'h0002, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("latency_mul", 32'hFFFFFFFE, 8'hFF, 2'b00, 1'b1);

    // Full-mode overflow into guard, then SAT
    step(3'b001, 16'h7FFF, 16'h7FFF, 1'b0);
    step(3'b010, 16'h7FFF, 16'h7FFF, 1'b0);
    step(3'b010, 16'h7FFF, 16'h7FFF, 1'b0);
    step(3'b010, 16'h7FFF, 16'h7FFF, 1'b0);
    step(3'b011, 16'h0, 16'h0, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("full_mac4", 32'hFFFC0004, 8'h00, 2'b00, 1'b1);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("full_sat", 32'h7FFFFFFF, 8'h00, 2'b11, 1'b1);

    // Lane MUL
    step(3'b101, 16'h80FF, 16'h7F02, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("lane_mul", 32'hC080FFFE, 8'hFF, 2'b00, 1'b1);

    // Lane MAC then SAT
    step(3'b101, 16'h007F, 16'h007F, 1'b0);
    step(3'b110, 16'h007F, 16'h007F, 1'b0);
    step(3'b110, 16'h007F, 16'h007F, 1'b0);
    lit("lane_mac1", 32'h00003F01, 8'h00, 2'b00, 1'b1);
    step(3'b111, 16'h0, 16'h0, 1'b0);
    lit("lane_mac2", 32'h00007E02, 8'h00, 2'b00, 1'b1);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("lane_mac3", 32'h0000BD03, 8'h00, 2'b00, 1'b1);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("lane_sat", 32'h00007FFF, 8'h00, 2'b01, 1'b1);

    // Stall with two valid entries in flight
    step(3'b001, 16'h0002, 16'h0003, 1'b0);
    step(3'b010, 16'h0002, 16'h0003, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'b010, 16'h1234, 16'h4321, 1'b1);
      lit("stall_hold", 32'h00007FFF, 8'h00, 2'b00, 1'b0);
    end
    step(3'b010, 16'h0002, 16'h0003, 1'b0);
    lit("drain_mul", 32'h00000006, 8'h00, 2'b00, 1'b1);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("drain_mac", 32'h0000000C, 8'h00, 2'b00, 1'b1);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("post_stall_mac", 32'h00000012, 8'h00, 2'b00, 1'b1);

    // Reset mid-operation
    step(3'b001, 16'h0001, 16'h0001, 1'b0);
    step(3'b010, 16'h0005, 16'h0005, 1'b0);
    step(3'b010, 16'h0005, 16'h0005, 1'b0);
    do_reset();
    step(3'b001, 16'h0003, 16'h0004, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("rst_flush", 32'h0, 8'h00, 2'b00, 1'b0);
    step(3'b000, 16'h0, 16'h0, 1'b0);
    lit("rst_relatency", 32'h0000000C, 8'h00, 2'b00, 1'b1);

    // Randomized run
    for (int n = 0; n < 800; n++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      logic        st;
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        a = 16'($urandom); b = 16'($urandom);
      end else begin
        a = {pick_byte(), pick_byte()};
        b = {pick_byte(), pick_byte()};
      end
      st = ($urandom_range(0, 6) == 0);
      step(op, a, b, st);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_simd.md
# mac_simd

Parametrised signed multiply-accumulate unit with guard-bit accumulator, per-lane SIMD mode, saturation and a stallable output queue. It is the next-generation replacement for the fixed 16-bit/2-lane MAC in the DSP datapath: width, lane count, guard bits and output-queue depth are parameters. Operand pairs arrive from the issue stage, and results leave through a `PIPE_DEPTH`-deep queue that freezes under `stall`.

## Interface

**Parameters**
- `DATA_W`, 16, operand width. Must be divisible by `LANES`.
- `LANES`, 2, SIMD lanes in lane mode. Power of two, ≥1. Lane operand width `L = DATA_W/LANES`.
- `GUARD`, 8, total guard bits. Must be divisible by `LANES`. Per-lane guard width `G = GUARD/LANES`.
- `PIPE_DEPTH`, 2, output queue stages, ≥1.

**Ports**
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `instruction`, input, 3: opcode, sampled on unstalled edges.
- `multiplier`, input, `DATA_W`: signed operand (per-lane signed in lane mode).
- `multiplicand`, input, `DATA_W`: signed operand (per-lane signed in lane mode).
- `stall`, input, 1: freezes the accumulator and the queue.
- `result`, output, `2*DATA_W`: low part of the queued accumulator snapshot.
- `protect`, output, `GUARD`: guard part of the queued snapshot.
- `sat`, output, `LANES`: per-lane flag, "this snapshot was clamped".
- `out_valid`, output, 1: the snapshot came from a MUL/MAC/SAT opcode.

## Operation

**Accumulator state**
- `acc_lo` is `2*DATA_W` bits; `acc_g` is `GUARD` bits.
- Full-mode value is the signed number `{acc_g, acc_lo}`.
- Lane i value is the signed number `{acc_g[i*G +: G], acc_lo[i*2L +: 2L]}`.
- Switching modes without a CLEAR reinterprets the same bits; no conversion is performed.

**Opcodes**
- `instruction[2]` selects lane mode, except code 100.
- 000 NOP: accumulator holds; the pushed entry has `out_valid=0`.
- 100 CLEAR: accumulator becomes 0; pushed with `out_valid=0`.
- 001 MUL: acc = sext(multiplier × multiplicand).
- 010 MAC: acc = acc + sext(product).
- 011 SAT: clamp acc to the signed `2*DATA_W` range.
- 101 / 110 / 111: lane-mode MUL / MAC / SAT, each lane independent. No carry crosses a lane boundary.

**Arithmetic rules**
- All products are two's-complement signed.
- Full-mode product is `2*DATA_W` bits; lane product is `2L` bits.
- Each product is sign-extended into its field, of width `2*DATA_W+GUARD` (full) or `2L+G` (lane).
- Addition wraps modulo the field width. No overflow flag is raised beyond `sat`.

**SAT**
- Value > 2^(n-1)-1 (n = `2*DATA_W` or `2L`): field becomes 0x7F..F and its guard bits become 0.
- Value < -2^(n-1): field becomes 0x80..0 and its guard bits become all-ones.
- Otherwise the field is unchanged.
- `sat[i]` is set for each clamped lane. In full mode a clamp sets all `sat` bits.
- Any opcode other than SAT pushes `sat=0`.

**Output queue**
- The queue has entries q[0..PIPE_DEPTH-1], each {acc_g, acc_lo, sat, valid}.
- On an unstalled edge, all of the following happen together:
  - outputs <= q[0];
  - q[k] <= q[k+1];
  - q[PIPE_DEPTH-1] <= the accumulator value after this edge's update.
- `stall=1`: the accumulator, queue and outputs all hold. `instruction` and operands are ignored, not deferred.

## Timing

- **Reset:** `reset` high clears the accumulator, every queue entry, `result`, `protect`, `sat` and `out_valid` to 0 immediately, without waiting for a clock edge. Reset mid-stream discards all in-flight entries.
- **Latency:** an opcode sampled at unstalled edge t is visible on the outputs after unstalled edge t+PIPE_DEPTH. That is `PIPE_DEPTH+1` edges; stalled edges do not count.
- **Throughput:** one opcode per unstalled cycle. Back-to-back MACs use the updated accumulator with no bubble.
- **Stall release:** on the first unstalled edge after a stall, the queue resumes exactly where it froze.
- **Reset and stall together:** reset wins.

## Test plan

Configuration for all scenarios: `DATA_W=16`, `LANES=2`, `GUARD=8`, `PIPE_DEPTH=2`. Lane width L=8, per-lane guard G=4.

1. **Reset and latency.** Reset, then MUL 0xFFFF × 0x0002 at edge 1, then NOPs. Required: all outputs 0 during reset. After edge 3: `result=0xFFFFFFFE`, `protect=0xFF`, `out_valid=1`, `sat=0`.
2. **Full-mode overflow and saturation.** MUL 0x7FFF × 0x7FFF, then three MACs with the same operands. Required: the fourth snapshot is `result=0xFFFC0004`, `protect=0x00`. A following SAT yields `result=0x7FFFFFFF`, `protect=0x00`, `sat=2'b11`.
3. **Lane MUL.** multiplier 0x80FF, multiplicand 0x7F02, opcode 101. Required: `result=0xC080FFFE`, `protect=0xFF`. This covers lane1 = -128×127 and lane0 = -1×2.
4. **Lane MAC then SAT.** 0x007F × 0x007F with opcode 101, then 110 twice, then 111. Required:
   - snapshots lane0 = 0x3F01, 0x7E02, 0xBD03 (guard 0);
   - after SAT, `result=0x00007FFF`, `sat=2'b01`;
   - lane1 stays 0 throughout.
5. **Stall.** Queue holds two valid entries; hold `stall=1` for 3 cycles while driving MAC opcodes. Required:
   - outputs and accumulator unchanged throughout the stall;
   - the MACs have no effect;
   - after release, the entries drain in their original order.
6. **Reset mid-operation.** Assert `reset` asynchronously between edges while MACs are in flight. Required: outputs go to 0 before the next edge. After deassertion, the first MUL result appears at the normal 3-edge latency.
